// File: rtl/cv32e40x_alu_b_bitcnt_seq.sv
// Iterative CPOP/CLZ/CTZ unit: consumes CHUNK_W operand bits per RUN cycle.
// Optional early termination under `CV32E40X_BITCNT_EARLY_EXIT_EN.
module cv32e40x_alu_b_bitcnt_seq #(
  parameter int unsigned CHUNK_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] operand_i,
  input  logic [1:0]  op_i,
  input  logic        kill_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [5:0]  result_o,
  output logic        busy_o
);

  localparam int unsigned N     = 32 / CHUNK_W;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (!(CHUNK_W == 1 || CHUNK_W == 2 || CHUNK_W == 4 ||
          CHUNK_W == 8 || CHUNK_W == 16 || CHUNK_W == 32)) begin : g_bad_chunk
      $error("CHUNK_W must be one of 1, 2, 4, 8, 16, 32");
    end
  endgenerate

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid never depends on ready, and a presented result is held
  // stable until it is taken. kill_i overrides both sides.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [31:0]        sr_q, sr_d;
  logic [1:0]         op_q, op_d;
  logic [5:0]         acc_q, acc_d;
  logic               found_q, found_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         res_q, res_d;

  logic [CHUNK_W-1:0] chunk;
  logic [5:0]         chunk_pop;
  logic [5:0]         chunk_tz;
  logic [31:0]        operand_rev;
  logic               is_cpop;
  logic               finish;

  assign chunk   = sr_q[CHUNK_W-1:0];
  assign is_cpop = (op_q == 2'b00) || (op_q == 2'b11);

  always_comb begin
    chunk_pop = '0;
    chunk_tz  = 6'(CHUNK_W);
    for (int i = 0; i < int'(CHUNK_W); i++) begin
      chunk_pop = chunk_pop + 6'(chunk[i]);
    end
    for (int i = int'(CHUNK_W) - 1; i >= 0; i--) begin
      if (chunk[i]) chunk_tz = 6'(i);
    end
  end

  // CLZ is computed as CTZ of the bit-reversed operand.
  always_comb begin
    operand_rev = '0;
    for (int i = 0; i < 32; i++) begin
      operand_rev[i] = operand_i[31-i];
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    op_d       = op_q;
    acc_d      = acc_q;
    found_d    = found_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    in_ready_o = 1'b0;
    finish     = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_o = !kill_i;
        if (in_valid_i && !kill_i) begin
          sr_d    = (op_i == 2'b01) ? operand_rev : operand_i;
          op_d    = op_i;
          acc_d   = '0;
          found_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (is_cpop) begin
          acc_d = acc_q + chunk_pop;
        end else if (!found_q) begin
          acc_d = acc_q + chunk_tz;
          if (chunk != '0) found_d = 1'b1;
        end
        sr_d   = sr_q >> CHUNK_W;
        cnt_d  = cnt_q + CNT_W'(1);
        finish = (cnt_q == CNT_W'(N - 1));
`ifdef CV32E40X_BITCNT_EARLY_EXIT_EN
        finish = finish || (is_cpop ? (sr_d == '0) : found_d);
`endif
        if (finish) begin
          state_d = DONE;
          res_d   = acc_d;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (kill_i) begin
      state_d = IDLE;
      sr_d    = '0;
      acc_d   = '0;
      found_d = 1'b0;
      cnt_d   = '0;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      found_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      found_q <= found_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign result_o    = res_q;

endmodule

// File: tb/tb_cv32e40x_alu_b_bitcnt_seq.sv
// Bench for cv32e40x_alu_b_bitcnt_seq: directed requests, bit-level count model,
// per-cycle compare against an expected-result queue.
module tb_cv32e40x_alu_b_bitcnt_seq;

  localparam int CW = 8;
  localparam int N  = 32 / CW;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand;
  logic [1:0]  op;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  result;
  logic        busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cv32e40x_alu_b_bitcnt_seq #(.CHUNK_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .operand_i   (operand),
    .op_i        (op),
    .kill_i      (kill),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .busy_o      (busy)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [5:0]  exp_q[$];
  int          exp_cyc_q[$];
  bit          hold_active = 1'b0;
  logic [5:0]  hold_val = '0;
  int          ec;
  int          n_results = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int model_count(input logic [1:0] o, input logic [31:0] x);
    int n;
    n = 32;
    case (o)
      2'b01: for (int i = 0; i < 32; i++) if (x[i]) n = 31 - i;
      2'b10: for (int i = 31; i >= 0; i--) if (x[i]) n = i;
      default: n = $countones(x);
    endcase
    return n;
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] x);
    int hi, lo, l;
    hi = -1;
    lo = -1;
    for (int i = 0; i < 32; i++) begin
      if (x[i]) begin
        hi = i;
        if (lo < 0) lo = i;
      end
    end
    l = N;
`ifdef CV32E40X_BITCNT_EARLY_EXIT_EN
    case (o)
      2'b01:   l = (hi < 0) ? N : (31 - hi) / CW + 1;
      2'b10:   l = (lo < 0) ? N : lo / CW + 1;
      default: l = (hi < 0) ? 1 : hi / CW + 1;
    endcase
`endif
    return l;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      hold_active = 1'b0;
    end else begin
      if (kill) check("kill_blocks_ready", in_ready, 0);
      if (out_valid) begin
        if (!hold_active) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", out_valid, 0);
          end else begin
            hold_val = exp_q.pop_front();
            ec       = exp_cyc_q.pop_front();
            check("result", result, hold_val);
            check("latency", cyc, ec);
            hold_active = 1'b1;
          end
        end else begin
          check("result_hold", result, hold_val);
        end
        check("ready_low_done", in_ready, 0);
        check("busy_done", busy, 1);
        if (out_ready || kill) begin
          if (out_ready && !kill && hold_active) n_results++;
          hold_active = 1'b0;
        end
      end else begin
        if (hold_active) check("valid_dropped", out_valid, 1);
        hold_active = 1'b0;
        if (exp_q.size() != 0) begin
          check("busy_run", busy, 1);
          check("ready_low_run", in_ready, 0);
        end else if (!kill) begin
          check("idle_busy", busy, 0);
          check("idle_ready", in_ready, 1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] o, input logic [31:0] x,
                       input int hand_res, input int hand_lat_ee);
    int  m, l, hl;
    bit  accepted, rdy;
    m = model_count(o, x);
    l = model_lat(o, x);
`ifdef CV32E40X_BITCNT_EARLY_EXIT_EN
    hl = hand_lat_ee;
`else
    hl = N + 0 * hand_lat_ee;
`endif
    check("model_pin_res", m, hand_res);
    check("model_pin_lat", l, hl);
    op       = o;
    operand  = x;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 50 && !accepted; k++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      accepted = rdy;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      check("accept_timeout", accepted, 1);
    end else begin
      exp_q.push_back(6'(m));
      exp_cyc_q.push_back(cyc + l);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !hold_active && !out_valid) done = 1'b1;
    end
    if (!done) check("drain_timeout", done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) check("valid_timeout", seen, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nr;
    rst       = 1'b1;
    in_valid  = 1'b0;
    kill      = 1'b0;
    out_ready = 1'b1;
    op        = 2'b00;
    operand   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // basic functions
    issue(2'b00, 32'hFFFF_FFFF, 32, 4); wait_idle();
    issue(2'b01, 32'h0001_0000, 15, 2); wait_idle();
    issue(2'b10, 32'h0001_0000, 16, 3); wait_idle();
    issue(2'b01, 32'h0000_0000, 32, 4); wait_idle();
    issue(2'b10, 32'h0000_0000, 32, 4); wait_idle();
    issue(2'b00, 32'h0000_0000, 0, 1);  wait_idle();
    issue(2'b00, 32'h1234_5678, 13, 4); wait_idle();

    // backpressure
    out_ready = 1'b0;
    issue(2'b00, 32'h8000_0001, 2, 4);
    wait_valid();
    nr = n_results;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();
    check("single_result", n_results, nr + 1);

    // kill in the second RUN cycle, then a fresh request
    issue(2'b00, 32'hFFFF_FFFF, 32, 4);
    @(posedge clk);
    #1 kill = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    check("kill_busy", busy, 0);
    check("kill_result", result, 0);
    check("kill_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    issue(2'b10, 32'h0000_0080, 7, 1); wait_idle();

    // kill together with a request in IDLE
    op       = 2'b00;
    operand  = 32'h0000_00FF;
    in_valid = 1'b1;
    kill     = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    kill     = 1'b0;
    @(negedge clk);
    check("kill_no_accept", busy, 0);
    @(posedge clk);
    #1;

    // reset while a result is waiting
    out_ready = 1'b0;
    issue(2'b01, 32'h0000_0001, 31, 4);
    wait_valid();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_done_out_valid", out_valid, 0);
    check("rst_done_result", result, 0);
    check("rst_done_busy", busy, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // reserved op behaves as CPOP
    issue(2'b11, 32'h0000_00F0, 4, 1); wait_idle();

    // early-exit latency cases
    issue(2'b00, 32'h0000_0003, 2, 1);  wait_idle();
    issue(2'b10, 32'h0100_0000, 24, 4); wait_idle();
    issue(2'b01, 32'h8000_0000, 0, 1);  wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
